hc_enc_arb: RTL and testbench
=============================

HC_ENC_ARB -- requirements
Module: hc_enc_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one Hamming(7,4) encoder (range 2..8).
REQ-002 SHALL have parameter DATA_WD, default 4, data bits per request (fixed at 4).
REQ-003 SHALL have parameter CHK_WD, default 3, check bits per codeword (fixed at 3).
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_req_vld, input, NUM_REQ, per-requester data valid.
REQ-007 SHALL have port i_req_data, input, NUM_REQ*4, requester n data in bits [4n+3:4n], mapped to encoder i_data[4:1].
REQ-008 SHALL have port o_req_rdy, output, NUM_REQ, one-hot grant; requester n transfers when i_req_vld[n] and o_req_rdy[n] are both high.
REQ-009 SHALL have port o_enc_vld, output, 1, codeword valid.
REQ-010 SHALL have port o_enc_data, output, 7 ([7:1]), Hamming(7,4) codeword.
REQ-011 SHALL have port o_enc_id, output, $clog2(NUM_REQ), index of the source requester.
REQ-012 SHALL have port i_enc_rdy, input, 1, downstream ready; output transfers when o_enc_vld and i_enc_rdy are both high.

Function
REQ-013 SHALL encode as bit1=d1^d2^d4, bit2=d1^d3^d4, bit4=d2^d3^d4, bit3=d1, bit5=d2, bit6=d3, bit7=d4.
REQ-014 SHALL hold a single-entry output register (codeword, id, valid) with FSM states EMPTY (o_enc_vld=0) and FULL (o_enc_vld=1).
REQ-015 SHALL accept a request when in EMPTY, or in FULL when i_enc_rdy=1 in the same cycle (pass-through, no bubble).
REQ-016 SHALL drive o_req_rdy=0 for all requesters when in FULL and i_enc_rdy=0.
REQ-017 SHALL assert at most one o_req_rdy bit, only for a requester with i_req_vld=1; o_req_rdy is combinational from i_req_vld, the pointer and the state.
REQ-018 SHALL grant by round-robin: search starts at index (last_grant+1) mod NUM_REQ and wraps from NUM_REQ-1 to 0.
REQ-019 SHALL update last_grant only on an accepted transfer.
REQ-020 SHALL give one-cycle latency: data accepted at edge k appears on o_enc_vld/o_enc_data/o_enc_id after edge k.
REQ-021 SHALL keep o_enc_data and o_enc_id stable while o_enc_vld=1 and i_enc_rdy=0.
REQ-022 SHALL transition FULL->EMPTY when a transfer completes with no new accept; FULL->FULL on transfer plus accept; EMPTY->FULL on accept.
REQ-023 SHALL ignore i_req_data of non-granted requesters; requesters may drop valid without penalty when not granted.

Reset
REQ-024 SHALL, on i_rst=1 at a clock edge, force state EMPTY, o_enc_vld=0, o_enc_data=7'b0, o_enc_id=0 and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-025 SHALL hold o_req_rdy at all zeros while i_rst=1; a codeword held at reset is discarded, not delivered.

Configuration
REQ-026 SHALL, with macro HC_ENC_ARB_ERR_INJ_EN defined, add input i_inj_pos (3 bits); at accept, a value 1..7 inverts that bit of the registered codeword and 0 injects nothing.
REQ-027 SHALL, without HC_ENC_ARB_ERR_INJ_EN, omit i_inj_pos and always register the exact codeword.

Verification
REQ-028 SHALL cover: reset, then i_req_vld=4'b0001, data0=4'b1011, i_enc_rdy=1 -> next cycle o_enc_vld=1, o_enc_data=7'b1010101, o_enc_id=0.
REQ-029 SHALL cover: all four valid continuously, i_enc_rdy=1 -> grants 0,1,2,3,0 on consecutive cycles and o_enc_vld stays high with no bubble.
REQ-030 SHALL cover: FULL with i_enc_rdy=0 for 3 cycles -> o_req_rdy=0, output frozen; rdy=1 then gives transfer plus new accept in the same cycle.
REQ-031 SHALL cover: data 4'b1111 -> 7'b1111111, 4'b0001 -> 7'b0000111, 4'b0000 -> 7'b0000000.
REQ-032 SHALL cover: i_rst asserted while FULL -> next cycle o_enc_vld=0, then first grant goes to requester 0 although requester 2 was next.
REQ-033 SHALL cover: with HC_ENC_ARB_ERR_INJ_EN, data 4'b1011, i_inj_pos=3 -> o_enc_data=7'b1010001.

Source files
------------

// File: rtl/hc_enc_arb.sv
// hc_enc_arb
// Round-robin arbiter in front of one shared Hamming(7,4) encoder. It has a
// single-entry output register that can pass data straight through.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_inj_pos   (HC_ENC_ARB_ERR_INJ_EN only) at accept, a value 1..7 flips
//               that codeword bit; 0 flips nothing
//   i_req_vld   per-requester data valid
//   i_req_data  requester n data in bits [4n+3:4n]
//   o_req_rdy   one-hot grant, combinational
//   o_enc_vld   codeword valid (registered)
//   o_enc_data  codeword [7:1] (registered)
//   o_enc_id    index of the source requester (registered)
//   i_enc_rdy   downstream ready
//
// Optional feature: define HC_ENC_ARB_ERR_INJ_EN to add the i_inj_pos
// error-injection input.
module hc_enc_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
`ifdef HC_ENC_ARB_ERR_INJ_EN
    input  logic [2:0]                     i_inj_pos,
`endif
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ*DATA_WD-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]             o_req_rdy,
    output logic                           o_enc_vld,
    output logic [DATA_WD+CHK_WD:1]        o_enc_data,
    output logic [$clog2(NUM_REQ)-1:0]     o_enc_id,
    input  logic                           i_enc_rdy
);

    localparam int ID_WD = $clog2(NUM_REQ);
    localparam int CW_WD = DATA_WD + CHK_WD;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_r;
    logic               enc_vld_r;
    logic [CW_WD:1]     enc_data_r;
    logic [ID_WD-1:0]   enc_id_r;
    logic [ID_WD-1:0]   last_grant_r;

    logic               accept_en_s;
    logic               found_s;
    logic               accept_s;
    logic [ID_WD-1:0]   idx_s;
    logic [ID_WD-1:0]   gnt_id_s;
    logic [DATA_WD:1]   req_data_s;
    logic [CW_WD:1]     cw_s;

    // Hamming(7,4). Parity bits sit at positions 1, 2 and 4. Data bits fill positions 3, 5, 6 and 7.
    function automatic logic [CW_WD:1] hamming_enc(input logic [DATA_WD:1] d);
        logic [CW_WD:1] cw;
        cw    = '0;
        cw[1] = d[1] ^ d[2] ^ d[4];
        cw[2] = d[1] ^ d[3] ^ d[4];
        cw[3] = d[1];
        cw[4] = d[2] ^ d[3] ^ d[4];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[7] = d[4];
        return cw;
    endfunction

    // Round-robin search. It starts just after the last granted index and wraps at NUM_REQ.
    always_comb begin
        accept_en_s = ~i_rst & ((state_r == ST_EMPTY) | i_enc_rdy);
        found_s     = 1'b0;
        gnt_id_s    = '0;
        idx_s       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_WD'((int'(last_grant_r) + k) % NUM_REQ);
            if (!found_s && i_req_vld[idx_s]) begin
                found_s  = 1'b1;
                gnt_id_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
        accept_s = found_s & accept_en_s;
        if (accept_s) begin
            o_req_rdy = NUM_REQ'(1) << gnt_id_s;
        end else begin
            o_req_rdy = '0;
        end
    end

    // Select the granted requester's data. Data from requesters without a grant is ignored.
    always_comb begin
        req_data_s = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (gnt_id_s == ID_WD'(n)) begin
                req_data_s = i_req_data[n*DATA_WD +: DATA_WD];
            end else begin
                req_data_s = req_data_s;
            end
        end
    end

`ifdef HC_ENC_ARB_ERR_INJ_EN
    // Codeword to register. A nonzero i_inj_pos flips the bit at that position.
    always_comb begin
        if (i_inj_pos == 3'd0) begin
            cw_s = hamming_enc(req_data_s);
        end else begin
            cw_s = hamming_enc(req_data_s) ^ (CW_WD'(1) << (i_inj_pos - 3'd1));
        end
    end
`else
    // Codeword to register, exactly as encoded
    always_comb begin
        cw_s = hamming_enc(req_data_s);
    end
`endif

    // EMPTY/FULL state machine. It holds the single-entry output register and the round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_EMPTY;
            enc_vld_r    <= 1'b0;
            enc_data_r   <= '0;
            enc_id_r     <= '0;
            last_grant_r <= ID_WD'(NUM_REQ - 1);
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r      <= ST_FULL;
                        enc_vld_r    <= 1'b1;
                        enc_data_r   <= cw_s;
                        enc_id_r     <= gnt_id_s;
                        last_grant_r <= gnt_id_s;
                    end else begin
                        state_r      <= ST_EMPTY;
                        enc_vld_r    <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        // The old word leaves and the new word loads in the same cycle
                        state_r      <= ST_FULL;
                        enc_vld_r    <= 1'b1;
                        enc_data_r   <= cw_s;
                        enc_id_r     <= gnt_id_s;
                        last_grant_r <= gnt_id_s;
                    end else if (i_enc_rdy) begin
                        state_r      <= ST_EMPTY;
                        enc_vld_r    <= 1'b0;
                    end else begin
                        state_r      <= ST_FULL;
                        enc_vld_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_EMPTY;
                    enc_vld_r    <= 1'b0;
                end
            endcase
        end
    end

    assign o_enc_vld  = enc_vld_r;
    assign o_enc_data = enc_data_r;
    assign o_enc_id   = enc_id_r;

endmodule

// File: tb/tb_hc_enc_arb.sv
// Self-checking bench for hc_enc_arb (NUM_REQ=4). It runs directed scenarios
// and then randomized traffic, all against a behavioural model of the
// arbiter and encoder.
module tb_hc_enc_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   vld;
    logic [4*N-1:0] data;
    logic [N-1:0]   rdy;
    logic           enc_vld;
    logic [7:1]     enc_data;
    logic [1:0]     enc_id;
    logic           enc_rdy;
    logic [2:0]     inj_pos;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the output slot and the round-robin pointer
    bit         m_known = 1'b0;
    bit         m_vld   = 1'b0;
    logic [6:0] m_data  = 7'd0;
    int         m_id    = 0;
    int         m_last  = N - 1;

    logic [3:0] t_d [3] = '{4'hF, 4'h1, 4'h0};
    logic [6:0] t_c [3] = '{7'h7F, 7'h07, 7'h00};
    logic [7:1] held;

    always #5 clk = ~clk;

    hc_enc_arb #(.NUM_REQ(N), .DATA_WD(4), .CHK_WD(3)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
`ifdef HC_ENC_ARB_ERR_INJ_EN
        .i_inj_pos  (inj_pos),
`endif
        .i_req_vld  (vld),
        .i_req_data (data),
        .o_req_rdy  (rdy),
        .o_enc_vld  (enc_vld),
        .o_enc_data (enc_data),
        .o_enc_id   (enc_id),
        .i_enc_rdy  (enc_rdy)
    );

    function automatic logic [6:0] ref_enc(input logic [3:0] d, input int inj);
        int d1, d2, d3, d4, p1, p2, p4;
        logic [6:0] v;
        d1 = int'(d[0]); d2 = int'(d[1]); d3 = int'(d[2]); d4 = int'(d[3]);
        p1 = (d1 + d2 + d4) % 2;
        p2 = (d1 + d3 + d4) % 2;
        p4 = (d2 + d3 + d4) % 2;
        v = 7'(d4 * 64 + d3 * 32 + d2 * 16 + p4 * 8 + d1 * 4 + p2 * 2 + p1);
        if (inj != 0) v = v ^ 7'(1 << (inj - 1));
        return v;
    endfunction

    function automatic int ref_grant();
        if (rst) return -1;
        if (m_vld && !enc_rdy) return -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Check the DUT against the model, take the edge,
    // update the model, and return at the next falling edge.
    task automatic cycle();
        int g;
        #1;
        g = ref_grant();
        chk("model_rdy", 32'(rdy), (g < 0) ? 32'd0 : 32'(1 << g));
        if (m_known) begin
            chk("model_vld",  32'(enc_vld),  32'(m_vld));
            chk("model_data", 32'(enc_data), 32'(m_data));
            chk("model_id",   32'(enc_id),   32'(m_id));
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1'b1;
            m_vld   = 1'b0;
            m_data  = 7'd0;
            m_id    = 0;
            m_last  = N - 1;
        end else if (g >= 0) begin
            m_vld  = 1'b1;
            m_data = ref_enc(data[4*g +: 4], int'(inj_pos));
            m_id   = g;
            m_last = g;
        end else if (m_vld && enc_rdy) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; vld = '1; data = '0; enc_rdy = 1'b1; inj_pos = 3'd0;
        @(negedge clk);

        // Reset: no grant while in reset, and the outputs clear
        #1 chk("rst_rdy", 32'(rdy), 32'd0);
        cycle();
        cycle();
        chk("rst_vld",  32'(enc_vld),  32'd0);
        chk("rst_data", 32'(enc_data), 32'd0);
        chk("rst_id",   32'(enc_id),   32'd0);

        // Single request from requester 0 with data 1011
        rst = 1'b0; vld = 4'b0001; data = 16'h000B; enc_rdy = 1'b1;
        #1 chk("r028_rdy", 32'(rdy), 32'h1);
        cycle();
        chk("r028_vld",  32'(enc_vld),  32'd1);
        chk("r028_data", 32'(enc_data), 32'h55);
        chk("r028_id",   32'(enc_id),   32'd0);
        vld = 4'b0000;
        cycle();

        // All four requesters valid: grants rotate 0,1,2,3,0 with no bubble
        rst = 1'b1; cycle(); rst = 1'b0;
        vld = 4'b1111; data = 16'h9C3A;
        for (int i = 0; i < 5; i++) begin
            #1 chk("r029_gnt", 32'(rdy), 32'(1 << (i % 4)));
            cycle();
            chk("r029_vld", 32'(enc_vld), 32'd1);
            chk("r029_id",  32'(enc_id),  32'(i % 4));
        end

        // Downstream stalls for 3 cycles: no grant, output frozen
        enc_rdy = 1'b0;
        held = enc_data;
        for (int i = 0; i < 3; i++) begin
            #1 chk("r030_rdy0", 32'(rdy), 32'd0);
            cycle();
            chk("r030_vld",  32'(enc_vld),  32'd1);
            chk("r030_hold", 32'(enc_data), 32'(held));
            chk("r030_id",   32'(enc_id),   32'd0);
        end
        enc_rdy = 1'b1;
        #1 chk("r030_pass", 32'(rdy), 32'h2);
        cycle();
        chk("r030_vld2", 32'(enc_vld), 32'd1);
        chk("r030_id2",  32'(enc_id),  32'd1);

        // Codeword table
        rst = 1'b1; cycle(); rst = 1'b0;
        vld = 4'b0001; enc_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = {12'h000, t_d[i]};
            cycle();
            chk("r031_cw", 32'(enc_data), 32'(t_c[i]));
        end

        // Reset while FULL discards the word; requester 0 gets priority again
        rst = 1'b1; cycle(); rst = 1'b0;
        vld = 4'b1111; enc_rdy = 1'b1; data = 16'h5A5A;
        cycle();
        cycle();
        chk("r032_id1", 32'(enc_id), 32'd1);
        enc_rdy = 1'b0;
        rst = 1'b1;
        #1 chk("r032_rdy_rst", 32'(rdy), 32'd0);
        cycle();
        chk("r032_vld0", 32'(enc_vld), 32'd0);
        rst = 1'b0;
        #1 chk("r032_gnt0", 32'(rdy), 32'h1);
        cycle();
        chk("r032_id0", 32'(enc_id), 32'd0);

`ifdef HC_ENC_ARB_ERR_INJ_EN
        // Error injection at bit 3
        rst = 1'b1; cycle(); rst = 1'b0;
        vld = 4'b0001; data = 16'h000B; enc_rdy = 1'b1; inj_pos = 3'd3;
        cycle();
        chk("r033_inj", 32'(enc_data), 32'h51);
        inj_pos = 3'd0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 39) == 0);
            vld     = 4'($urandom_range(0, 15));
            data    = 16'($urandom);
            enc_rdy = ($urandom_range(0, 3) != 0);
`ifdef HC_ENC_ARB_ERR_INJ_EN
            inj_pos = 3'($urandom_range(0, 7));
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
